// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush controller for the 5-stage F/D/E/M/W pipeline.
//
// Detects the hazards forwarding cannot cover (load-use, branch operands resolved
// in D, HI/LO unit still busy), memory handshake stalls and exception flushes, and
// publishes per-stage stall/flush enables. Also sequences the multi-cycle MULT/DIV
// unit.
//
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   rsD, rtD             D-stage source registers
//   useRsD, useRtD       D instruction actually reads rs / rt
//   branchD              D instruction is a branch/JR resolved in D
//   rdE, regWriteE       E-stage destination and its write enable
//   memReadE             E instruction is a load
//   rdM, memReadM        M-stage destination, M instruction is a load
//   iBusy, dBusy         instruction / data request outstanding
//   mdStartE, mdIsDivE   E instruction is a mult/div, and whether it divides
//   mdUseD               D instruction touches HI/LO or the mult/div unit
//   excM                 exception/ERET committed in M
//   stallF..stallM       hold PC, F/D, D/E, E/M registers
//   flushD..flushW       clear F/D, D/E, E/M, M/W registers to a bubble
//   mdBusy, mdDone       HI/LO unit occupied, one-cycle completion pulse

module pipe_ctrl #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 32,
  parameter int unsigned CNT_W      = 6
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic       useRsD,
  input  logic       useRtD,
  input  logic       branchD,
  input  logic [4:0] rdE,
  input  logic       regWriteE,
  input  logic       memReadE,
  input  logic [4:0] rdM,
  input  logic       memReadM,
  input  logic       iBusy,
  input  logic       dBusy,
  input  logic       mdStartE,
  input  logic       mdIsDivE,
  input  logic       mdUseD,
  input  logic       excM,
  output logic       stallF,
  output logic       stallD,
  output logic       stallE,
  output logic       stallM,
  output logic       flushD,
  output logic       flushE,
  output logic       flushM,
  output logic       flushW,
  output logic       mdBusy,
  output logic       mdDone
);

  typedef enum logic {StIdle, StBusy} state_e;

  localparam logic [CNT_W-1:0] MulLoad = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DivLoad = CNT_W'(DIV_CYCLES - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;

  logic mem_stall;
  logic load_use;
  logic br_haz;
  logic md_haz;
  logic stall_e;
  logic flush_e;
  logic md_start;

  // Hazard detection. Register 0 is hardwired, so it never creates a dependency.
  always_comb begin
    mem_stall = iBusy | dBusy;
    load_use  = memReadE && (rdE != 5'd0) &&
                ((useRsD && (rsD == rdE)) || (useRtD && (rtD == rdE)));
    br_haz    = branchD &&
                ((regWriteE && (rdE != 5'd0) && ((rsD == rdE) || (rtD == rdE))) ||
                 (memReadM && (rdM != 5'd0) && ((rsD == rdM) || (rtD == rdM))));
    md_haz    = mdUseD && (state_q == StBusy);
  end

  // Priority: memory stall freezes everything (excM is held by its source until
  // the stall clears), then exception flush, then the D-stage hazards.
  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    flushM = 1'b0;
    flushW = 1'b0;
    if (resetn) begin
      if (mem_stall) begin
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        stallM = 1'b1;
        flushW = 1'b1;
      end else if (excM) begin
        flushD = 1'b1;
        flushE = 1'b1;
        flushM = 1'b1;
      end else if (load_use || br_haz || md_haz) begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushE = 1'b1;
      end
    end
  end

  always_comb begin
    stall_e  = mem_stall;
    flush_e  = !mem_stall && (excM || load_use || br_haz || md_haz);
    md_start = mdStartE && !stall_e && !flush_e && !excM;
    mdBusy   = resetn && (state_q == StBusy);
    mdDone   = resetn && (state_q == StBusy) && (cnt_q == '0);
  end

  // Mult/div sequencer. The counter keeps running through memory stalls and an
  // exception does not abort it: the op belongs to an older instruction.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (md_start) begin
            state_q <= StBusy;
            cnt_q   <= mdIsDivE ? DivLoad : MulLoad;
          end
        end
        StBusy: begin
          // A stray mdStartE here is ignored.
          if (cnt_q == '0) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: directed scenarios followed by random stimulus. Each
// cycle's expected outputs come from a reference model and go into a queue; a
// monitor on the falling edge pops and compares them against the DUT.

module tb_pipe_ctrl;

  typedef struct packed {
    logic       resetn;
    logic [4:0] rsD;
    logic [4:0] rtD;
    logic       useRsD;
    logic       useRtD;
    logic       branchD;
    logic [4:0] rdE;
    logic       regWriteE;
    logic       memReadE;
    logic [4:0] rdM;
    logic       memReadM;
    logic       iBusy;
    logic       dBusy;
    logic       mdStartE;
    logic       mdIsDivE;
    logic       mdUseD;
    logic       excM;
  } in_t;

  // Output vector order: stallF stallD stallE stallM flushD flushE flushM flushW
  // mdBusy mdDone
  typedef logic [9:0] out_t;

  logic       clk = 1'b0;
  logic       resetn;
  logic [4:0] rsD, rtD, rdE, rdM;
  logic       useRsD, useRtD, branchD, regWriteE, memReadE, memReadM;
  logic       iBusy, dBusy, mdStartE, mdIsDivE, mdUseD, excM;
  logic       stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW;
  logic       mdBusy, mdDone;

  pipe_ctrl dut (
    .clk      (clk),
    .resetn   (resetn),
    .rsD      (rsD),
    .rtD      (rtD),
    .useRsD   (useRsD),
    .useRtD   (useRtD),
    .branchD  (branchD),
    .rdE      (rdE),
    .regWriteE(regWriteE),
    .memReadE (memReadE),
    .rdM      (rdM),
    .memReadM (memReadM),
    .iBusy    (iBusy),
    .dBusy    (dBusy),
    .mdStartE (mdStartE),
    .mdIsDivE (mdIsDivE),
    .mdUseD   (mdUseD),
    .excM     (excM),
    .stallF   (stallF),
    .stallD   (stallD),
    .stallE   (stallE),
    .stallM   (stallM),
    .flushD   (flushD),
    .flushE   (flushE),
    .flushM   (flushM),
    .flushW   (flushW),
    .mdBusy   (mdBusy),
    .mdDone   (mdDone)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  int   cycle  = 0;
  out_t exp_q[$];

  // Reference model state: how many more cycles the HI/LO unit stays occupied.
  int   busy_left = 0;
  in_t  cur;
  out_t cur_exp;
  bit   have_prev = 0;

  function automatic out_t model_out(input in_t s, input int left);
    out_t o;
    bit   lu, bh, mh;
    o = '0;
    if (!s.resetn) return o;
    lu = s.memReadE && s.rdE != 0 &&
         ((s.useRsD && s.rsD == s.rdE) || (s.useRtD && s.rtD == s.rdE));
    bh = s.branchD &&
         ((s.regWriteE && s.rdE != 0 && (s.rsD == s.rdE || s.rtD == s.rdE)) ||
          (s.memReadM && s.rdM != 0 && (s.rsD == s.rdM || s.rtD == s.rdM)));
    mh = s.mdUseD && left > 0;
    if (s.iBusy || s.dBusy)       o[9:2] = 8'b1111_0001;
    else if (s.excM)              o[9:2] = 8'b0000_1110;
    else if (lu || bh || mh)      o[9:2] = 8'b1100_0100;
    o[1] = left > 0;
    o[0] = left == 1;
    return o;
  endfunction

  // Advance the model across the clock edge that consumed 'cur'.
  task automatic model_advance();
    if (!cur.resetn) busy_left = 0;
    else if (busy_left > 0) busy_left = busy_left - 1;
    else if (cur.mdStartE && !cur_exp[7] && !cur_exp[4] && !cur.excM)
      busy_left = cur.mdIsDivE ? 32 : 4;
  endtask

  task automatic apply(input in_t s);
    resetn = s.resetn;  rsD = s.rsD;  rtD = s.rtD;  useRsD = s.useRsD;
    useRtD = s.useRtD;  branchD = s.branchD;  rdE = s.rdE;
    regWriteE = s.regWriteE;  memReadE = s.memReadE;  rdM = s.rdM;
    memReadM = s.memReadM;  iBusy = s.iBusy;  dBusy = s.dBusy;
    mdStartE = s.mdStartE;  mdIsDivE = s.mdIsDivE;  mdUseD = s.mdUseD;
    excM = s.excM;
  endtask

  task automatic step(input in_t s);
    @(posedge clk);
    if (have_prev) model_advance();
    #1;
    cur = s;
    apply(s);
    cur_exp = model_out(s, busy_left);
    exp_q.push_back(cur_exp);
    have_prev = 1;
  endtask

  function automatic in_t nop();
    in_t s;
    s = '0;
    s.resetn = 1'b1;
    return s;
  endfunction

  function automatic logic [4:0] rreg();
    case ($urandom_range(0, 3))
      0:       return 5'd0;
      1:       return 5'd8;
      2:       return 5'd9;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  function automatic in_t rnd();
    in_t s;
    s.resetn    = $urandom_range(0, 199) != 0;
    s.rsD       = rreg();
    s.rtD       = rreg();
    s.useRsD    = 1'($urandom_range(0, 1));
    s.useRtD    = 1'($urandom_range(0, 1));
    s.branchD   = $urandom_range(0, 3) == 0;
    s.rdE       = rreg();
    s.regWriteE = 1'($urandom_range(0, 1));
    s.memReadE  = $urandom_range(0, 2) == 0;
    s.rdM       = rreg();
    s.memReadM  = $urandom_range(0, 2) == 0;
    s.iBusy     = $urandom_range(0, 9) == 0;
    s.dBusy     = $urandom_range(0, 9) == 0;
    s.mdStartE  = $urandom_range(0, 3) == 0;
    s.mdIsDivE  = $urandom_range(0, 3) == 0;
    s.mdUseD    = $urandom_range(0, 3) == 0;
    s.excM      = $urandom_range(0, 15) == 0;
    return s;
  endfunction

  // Monitor: outputs are combinational, so every cycle presents a response.
  always @(negedge clk) begin
    out_t act, e;
    cycle = cycle + 1;
    if (exp_q.size() != 0) begin
      e   = exp_q.pop_front();
      act = {stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW,
             mdBusy, mdDone};
      checks = checks + 1;
      if (act[9:6] !== e[9:6]) begin
        errors = errors + 1;
        $display("FAIL stalls cycle %0d: got %b want %b (sF sD sE sM)",
                 cycle, act[9:6], e[9:6]);
      end
      checks = checks + 1;
      if (act[5:2] !== e[5:2]) begin
        errors = errors + 1;
        $display("FAIL flushes cycle %0d: got %b want %b (fD fE fM fW)",
                 cycle, act[5:2], e[5:2]);
      end
      checks = checks + 1;
      if (act[1:0] !== e[1:0]) begin
        errors = errors + 1;
        $display("FAIL muldiv cycle %0d: got %b want %b (busy done)",
                 cycle, act[1:0], e[1:0]);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t s;
    s = nop();
    s.resetn = 1'b0;
    apply(s);
    step(s);
    step(s);

    // Load-use on rs, then clear.
    s = nop(); s.memReadE = 1; s.rdE = 8; s.regWriteE = 1; s.rsD = 8; s.useRsD = 1;
    step(s);
    step(nop());
    // $0 never hazards.
    s = nop(); s.memReadE = 1; s.rdE = 0; s.rsD = 0; s.useRsD = 1;
    step(s);
    // Branch operand from ALU in E, then from a load in M.
    s = nop(); s.branchD = 1; s.rtD = 9; s.regWriteE = 1; s.rdE = 9;
    step(s);
    s = nop(); s.branchD = 1; s.rtD = 9; s.memReadM = 1; s.rdM = 9;
    step(s);
    // DIV in E, then MFLO waiting in D past the end of the operation.
    s = nop(); s.mdStartE = 1; s.mdIsDivE = 1;
    step(s);
    s = nop(); s.mdUseD = 1;
    repeat (34) step(s);
    // dBusy masks load-use for three cycles, then load-use shows.
    s = nop(); s.memReadE = 1; s.rdE = 8; s.rtD = 8; s.useRtD = 1; s.dBusy = 1;
    repeat (3) step(s);
    s.dBusy = 0;
    step(s);
    // Exception held under iBusy, then acted on.
    s = nop(); s.excM = 1; s.iBusy = 1;
    repeat (2) step(s);
    s.iBusy = 0;
    step(s);
    // MULT, reset while the counter is at 2, no completion pulse afterwards.
    s = nop(); s.mdStartE = 1;
    step(s);
    step(nop());
    s = nop(); s.resetn = 0;
    step(s);
    repeat (6) step(nop());

    repeat (3000) step(rnd());

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
